wt_dcache_rd_arbiter: RTL

- Parametrised read-port arbiter for the write-through L1 data cache, with N requesters (LD unit, PTW, write buffer, and optional extra load ports).
- Each cycle it grants at most one request to the single-ported tag/data SRAM and registers the winner's tag and port ID for the hit-compare stage one cycle later.
- Requests are split into high- and low-priority classes, with round-robin within each class.
- Starvation counters force a long-waiting low-priority port through.

---
 rtl/wt_dcache_rd_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/wt_dcache_rd_arbiter.sv
// Read-port arbiter for the write-through L1 data cache.
// Grants one requester per cycle to the tag/data SRAM and registers it for the compare stage.
//
// Ports:
//   clk_i, rst_i (async, active high), clr_i (sync clear)
//   wr_cl_vld_i      refill/invalidate owns the SRAM; blocks all grants
//   rd_req_i         per-port request, held until acked
//   rd_prio_i        per-port class, 1 = high priority
//   rd_tag_only_i    per-port tag-only read
//   rd_tag_i         per-port compare tag (packed)
//   rd_idx_i         per-port line index (packed)
//   rd_off_i         per-port byte offset (packed)
//   rd_ack_o         one-hot grant, same cycle as request
//   mem_en_o         SRAM read enable
//   mem_idx_o        SRAM index of the winner
//   mem_off_o        offset of the winner
//   mem_tag_only_o   suppresses the data-bank read
//   cmp_vld_o        compare stage valid, one cycle after the grant
//   cmp_port_o       port ID in the compare stage
//   cmp_tag_o        registered tag in the compare stage
//   starved_o        debug: low-priority port has waited StarveLimit cycles
module wt_dcache_rd_arbiter #(
    parameter int NumPorts    = 3,
    parameter int TagWidth    = 44,
    parameter int IdxWidth    = 8,
    parameter int OffWidth    = 4,
    parameter int StarveLimit = 8,
    parameter int PortIdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         wr_cl_vld_i,
    input  logic [NumPorts-1:0]          rd_req_i,
    input  logic [NumPorts-1:0]          rd_prio_i,
    input  logic [NumPorts-1:0]          rd_tag_only_i,
    input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
    input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
    input  logic [NumPorts*OffWidth-1:0] rd_off_i,
    output logic [NumPorts-1:0]          rd_ack_o,
    output logic                         mem_en_o,
    output logic [IdxWidth-1:0]          mem_idx_o,
    output logic [OffWidth-1:0]          mem_off_o,
    output logic                         mem_tag_only_o,
    output logic                         cmp_vld_o,
    output logic [PortIdxW-1:0]          cmp_port_o,
    output logic [TagWidth-1:0]          cmp_tag_o,
    output logic [NumPorts-1:0]          starved_o
);

    localparam int CntW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    typedef logic [PortIdxW-1:0] pidx_t;

    // Round-robin pick: first set bit at or above ptr, wrapping past NumPorts-1.
    function automatic logic [NumPorts-1:0] rr_pick(
        input logic [NumPorts-1:0] mask,
        input pidx_t               ptr
    );
        logic [NumPorts-1:0] oh;
        logic                found;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            for (int k = 0; k < NumPorts; k++) begin
                if (!found && mask[k] &&
                    ((int'(ptr) + i == k) || (int'(ptr) + i == k + NumPorts))) begin
                    oh[k] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return oh;
    endfunction

    pidx_t               hi_ptr_q, hi_ptr_d;
    pidx_t               lo_ptr_q, lo_ptr_d;
    logic [CntW-1:0]     cnt_q [NumPorts];
    logic [CntW-1:0]     cnt_d [NumPorts];
    logic                cmp_vld_q, cmp_vld_d;
    pidx_t               cmp_port_q, cmp_port_d;
    logic [TagWidth-1:0] cmp_tag_q, cmp_tag_d;

    logic [NumPorts-1:0] starved;
    logic [NumPorts-1:0] hi_req;
    logic [NumPorts-1:0] lo_req;
    logic [NumPorts-1:0] ack;
    pidx_t               win;
    pidx_t               win_nxt;

    always_comb begin
        hi_req = rd_req_i & rd_prio_i;
        lo_req = rd_req_i & ~rd_prio_i;
        for (int k = 0; k < NumPorts; k++) begin
            starved[k] = (StarveLimit != 0) && lo_req[k] && (cnt_q[k] == CntMax);
        end
    end

    // Grant selection: starved low ports first, then high class, then low class.
    always_comb begin
        ack = '0;
        if (!wr_cl_vld_i) begin
            if (|starved) begin
                ack = rr_pick(starved, lo_ptr_q);
            end else if (|hi_req) begin
                ack = rr_pick(hi_req, hi_ptr_q);
            end else if (|lo_req) begin
                ack = rr_pick(lo_req, lo_ptr_q);
            end
        end
    end

    always_comb begin
        win            = '0;
        mem_idx_o      = '0;
        mem_off_o      = '0;
        mem_tag_only_o = 1'b0;
        cmp_tag_d      = cmp_tag_q;
        for (int k = 0; k < NumPorts; k++) begin
            if (ack[k]) begin
                win            = pidx_t'(k);
                mem_idx_o      = rd_idx_i[k*IdxWidth +: IdxWidth];
                mem_off_o      = rd_off_i[k*OffWidth +: OffWidth];
                mem_tag_only_o = rd_tag_only_i[k];
                cmp_tag_d      = rd_tag_i[k*TagWidth +: TagWidth];
            end
        end
        win_nxt = (win == pidx_t'(NumPorts - 1)) ? '0 : win + pidx_t'(1);
    end

    always_comb begin
        hi_ptr_d   = hi_ptr_q;
        lo_ptr_d   = lo_ptr_q;
        cmp_vld_d  = |ack;
        cmp_port_d = cmp_port_q;
        if (|ack) begin
            cmp_port_d = win;
            if (rd_prio_i[win]) begin
                hi_ptr_d = win_nxt;
            end else begin
                lo_ptr_d = win_nxt;
            end
        end
        for (int k = 0; k < NumPorts; k++) begin
            cnt_d[k] = '0;
            if (lo_req[k] && !ack[k]) begin
                cnt_d[k] = (cnt_q[k] < CntMax) ? cnt_q[k] + 1'b1 : cnt_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_ptr_q   <= '0;
            lo_ptr_q   <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_port_q <= '0;
            cmp_tag_q  <= '0;
            for (int k = 0; k < NumPorts; k++) cnt_q[k] <= '0;
        end else if (clr_i) begin
            hi_ptr_q   <= '0;
            lo_ptr_q   <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_port_q <= '0;
            cmp_tag_q  <= '0;
            for (int k = 0; k < NumPorts; k++) cnt_q[k] <= '0;
        end else begin
            hi_ptr_q   <= hi_ptr_d;
            lo_ptr_q   <= lo_ptr_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_port_q <= cmp_port_d;
            cmp_tag_q  <= cmp_tag_d;
            for (int k = 0; k < NumPorts; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign rd_ack_o   = ack;
    assign mem_en_o   = |ack;
    assign cmp_vld_o  = cmp_vld_q;
    assign cmp_port_o = cmp_port_q;
    assign cmp_tag_o  = cmp_tag_q;
    assign starved_o  = starved;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(rd_ack_o)) else $error("rd_ack_o not onehot0");
            assert (mem_en_o == |rd_ack_o) else $error("mem_en_o inconsistent");
            assert (!(wr_cl_vld_i && |rd_ack_o)) else $error("ack during refill");
        end
    end
`endif

endmodule
